// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a prefetch FIFO and pipelined imem interface.
// Several requests may be in flight; flush redirects fetch and drops stale responses.
module if_prefetch_stage #(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC        = '0,
  parameter int unsigned     FIFO_DEPTH      = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            is_flush,
  input  logic [XLEN-1:0] branch_target,
  input  logic            is_stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            is_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW = (((PW + 1) > OW) ? (PW + 1) : OW) + 1;

  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt;
  logic [OW-1:0]   out_q, out_d, drop_q, drop_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, redirect_pc;
  logic [XLEN-1:0] mem_pc_q  [FIFO_DEPTH];
  logic [XLEN-1:0] mem_ins_q [FIFO_DEPTH];
  logic            can_req, hs, push, pop, unused_tgt_bits;

  assign fifo_cnt = wr_ptr_q - rd_ptr_q;

  // Only issue a request when a FIFO slot is reserved for its response.
  assign can_req  = (out_q < OW'(MAX_OUTSTANDING)) &&
                    ((SW'(out_q) + SW'(fifo_cnt)) < SW'(FIFO_DEPTH));
  assign imem_req  = reset_n && !is_flush && can_req;
  assign imem_addr = fetch_pc_q;
  assign hs        = imem_req && imem_gnt;

  assign push     = imem_rvalid && (drop_q == '0) && !is_flush;
  assign is_valid = (fifo_cnt != '0);
  assign pop      = is_valid && !is_stall && !is_flush;
  assign pc       = mem_pc_q[rd_ptr_q[PW-1:0]];
  assign instr    = mem_ins_q[rd_ptr_q[PW-1:0]];

  assign redirect_pc     = {branch_target[XLEN-1:2], 2'b00};
  assign unused_tgt_bits = ^branch_target[1:0];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_d     = drop_q;
    out_d      = out_q + OW'(hs) - OW'(imem_rvalid);
    if (hs) fetch_pc_d = fetch_pc_q + XLEN'(4);
    if (imem_rvalid && (drop_q != '0)) drop_d = drop_q - OW'(1);
    if (push) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
      wr_ptr_d  = wr_ptr_q + (PW + 1)'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + (PW + 1)'(1);
    // Every grant still unanswered after this edge belongs to the old path.
    if (is_flush) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      rd_ptr_d   = wr_ptr_q;
      drop_d     = out_q - OW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_pc_q[i]  <= '0;
        mem_ins_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      if (push) begin
        mem_pc_q[wr_ptr_q[PW-1:0]]  <= resp_pc_q;
        mem_ins_q[wr_ptr_q[PW-1:0]] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: imem model with configurable latency feeding an
// expected-instruction queue that is compared against the head each cycle.
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        reset_n, is_flush, is_stall, imem_gnt, imem_rvalid;
  logic [31:0] branch_target, imem_rdata;
  logic        imem_req, is_valid;
  logic [31:0] imem_addr, pc, instr;

  logic        w_gnt, w_req, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'h0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct { logic [31:0] addr; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  req_t        pend[$];
  exp_t        sb[$];
  logic [31:0] exp_pc = 32'h0;

  always #5 clk = ~clk;

  if_prefetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset_n(reset_n), .is_flush(is_flush), .branch_target(branch_target),
    .is_stall(is_stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .is_valid(is_valid), .pc(pc), .instr(instr)
  );

  if_prefetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .is_flush(zero_bit), .branch_target(zero_word),
    .is_stall(zero_bit), .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(zero_bit), .imem_rdata(zero_word), .is_valid(w_valid), .pc(w_pc), .instr(w_instr)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Memory responder: in-order responses, 'lat' cycles after the grant.
  always @(posedge clk) begin
    bit rst_seen;
    cyc++;
    rst_seen = !reset_n;
    #1;
    if (rst_seen || !reset_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = imem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
    end
  end

  // Scoreboard and invariant monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      sb.delete();
      exp_pc = 32'h0;
    end else begin
      total++;
      if (!(int'(dut.out_q) <= 2 && int'(dut.drop_q) <= int'(dut.out_q) &&
            int'(dut.out_q) + int'(dut.fifo_cnt) <= 4)) begin
        bad++;
        $display("FAIL invariant out=%0d drop=%0d cnt=%0d (limits 2, out, 4)",
                 dut.out_q, dut.drop_q, dut.fifo_cnt);
      end
      if (imem_req && imem_gnt) begin
        total++;
        if (imem_addr !== exp_pc) begin
          bad++;
          $display("FAIL req_addr got=%h exp=%h", imem_addr, exp_pc);
        end
        pend.push_back('{imem_addr, cyc + lat});
        sb.push_back('{exp_pc, imem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
      end
      if (is_valid) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL head_unexpected got pc=%h instr=%h exp=no entry", pc, instr);
        end else begin
          if (pc !== sb[0].pc || instr !== sb[0].ins) begin
            bad++;
            $display("FAIL head got pc=%h instr=%h exp pc=%h instr=%h", pc, instr, sb[0].pc, sb[0].ins);
          end
          if (!is_stall && !is_flush) void'(sb.pop_front());
        end
      end
      if (is_flush) begin
        sb.delete();
        exp_pc = {branch_target[31:2], 2'b00};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    tick();
    imem_gnt = 1'b0;
    is_stall = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pend.size() == 0 && !imem_rvalid && !is_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; is_flush = 1'b0; is_stall = 1'b0; imem_gnt = 1'b0;
    branch_target = 32'h0; w_gnt = 1'b0; lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 6;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    if (is_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", is_valid); end
    if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc); end
    if (instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
    if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL rst_wrap_addr got=%h exp=fffffffc", w_addr); end
  endtask

  task automatic test_stream();
    tick();
    reset_n  = 1'b1;
    imem_gnt = 1'b1;
    @(negedge clk);
    total += 3;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL s_req got=%b exp=1", imem_req); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL s_addr0 got=%h exp=0", imem_addr); end
    if (is_valid !== 1'b0) begin bad++; $display("FAIL s_valid_c0 got=%b exp=0", is_valid); end
    tick();
    @(negedge clk);
    total += 2;
    if (is_valid !== 1'b0) begin bad++; $display("FAIL s_valid_c1 got=%b exp=0", is_valid); end
    if (imem_addr !== 32'h4) begin bad++; $display("FAIL s_addr1 got=%h exp=4", imem_addr); end
    tick();
    @(negedge clk);
    total += 2;
    if (is_valid !== 1'b1) begin bad++; $display("FAIL s_valid_c2 got=%b exp=1", is_valid); end
    if (pc !== 32'h0) begin bad++; $display("FAIL s_first_pc got=%h exp=0", pc); end
    repeat (6) tick();
  endtask

  task automatic test_stall();
    tick();
    is_stall = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL st_req got=%b exp=0", imem_req); end
    if (is_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%b exp=1", is_valid); end
    tick();
    is_stall = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_flush();
    bit ok;
    bit seen;
    wait_idle(ok);
    total += 2;
    if (!ok) begin bad++; $display("FAIL fl_idle got=busy exp=idle"); end
    if (sb.size() != 0) begin bad++; $display("FAIL fl_sb_left got=%0d exp=0", sb.size()); end
    lat = 3;
    tick();
    imem_gnt = 1'b1;
    tick();
    tick();
    is_flush = 1'b1;
    branch_target = 32'h0000_0013;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL fl_req got=%b exp=0", imem_req); end
    tick();
    is_flush = 1'b0;
    @(negedge clk);
    total++;
    if (imem_addr !== 32'h10) begin bad++; $display("FAIL fl_addr got=%h exp=10", imem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_valid) begin seen = 1'b1; break; end
    end
    total += 2;
    if (!seen) begin bad++; $display("FAIL fl_timeout got=no valid exp=valid"); end
    if (pc !== 32'h10) begin bad++; $display("FAIL fl_first_pc got=%h exp=10", pc); end
    repeat (10) tick();
  endtask

  task automatic test_gnt_hold();
    bit ok;
    logic [31:0] hold_pc;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL gh_idle got=busy exp=idle"); end
    lat = 1;
    hold_pc = exp_pc;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      total += 3;
      if (imem_req !== 1'b1) begin bad++; $display("FAIL gh_req got=%b exp=1", imem_req); end
      if (imem_addr !== hold_pc) begin bad++; $display("FAIL gh_addr got=%h exp=%h", imem_addr, hold_pc); end
      if (is_valid !== 1'b0) begin bad++; $display("FAIL gh_valid got=%b exp=0", is_valid); end
    end
    tick();
    imem_gnt = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    total++;
    if (is_valid !== 1'b0) begin bad++; $display("FAIL gh_early got=%b exp=0", is_valid); end
    tick();
    @(negedge clk);
    total += 2;
    if (is_valid !== 1'b1) begin bad++; $display("FAIL gh_late got=%b exp=1", is_valid); end
    if (pc !== hold_pc) begin bad++; $display("FAIL gh_pc got=%h exp=%h", pc, hold_pc); end
    repeat (4) tick();
  endtask

  task automatic test_flush_stall();
    bit ok;
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL fs_idle got=busy exp=idle"); end
    lat = 1;
    tick();
    is_stall = 1'b1;
    imem_gnt = 1'b1;
    tick();
    tick();
    is_flush = 1'b1;
    branch_target = 32'h0000_0100;
    @(negedge clk);
    total += 2;
    if (imem_req !== 1'b0) begin bad++; $display("FAIL fs_req got=%b exp=0", imem_req); end
    if (imem_rvalid !== 1'b1 || is_valid !== 1'b1) begin
      bad++; $display("FAIL fs_setup got rvalid=%b valid=%b exp=1,1", imem_rvalid, is_valid);
    end
    tick();
    is_flush = 1'b0;
    @(negedge clk);
    total += 2;
    if (is_valid !== 1'b0) begin bad++; $display("FAIL fs_valid got=%b exp=0", is_valid); end
    if (imem_addr !== 32'h100) begin bad++; $display("FAIL fs_addr got=%h exp=100", imem_addr); end
    tick();
    is_stall = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    repeat (3) tick();
    #3;
    reset_n = 1'b0;
    #1;
    total += 2;
    if (is_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", is_valid); end
    if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", imem_req); end
    @(negedge clk);
    total++;
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h exp=0", imem_addr); end
    repeat (2) @(posedge clk);
    tick();
    reset_n  = 1'b1;
    imem_gnt = 1'b1;
    w_gnt    = 1'b1;
    @(negedge clk);
    total += 4;
    if (imem_req !== 1'b1) begin bad++; $display("FAIL rm_restart_req got=%b exp=1", imem_req); end
    if (imem_addr !== 32'h0) begin bad++; $display("FAIL rm_restart_addr got=%h exp=0", imem_addr); end
    if (w_req !== 1'b1) begin bad++; $display("FAIL wrap_req got=%b exp=1", w_req); end
    if (w_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr0 got=%h exp=fffffffc", w_addr); end
    tick();
    w_gnt = 1'b0;
    @(negedge clk);
    total++;
    if (w_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr1 got=%h exp=0", w_addr); end
    repeat (6) tick();
  endtask

  initial begin
    reset_n = 1'b0; is_flush = 1'b0; is_stall = 1'b0; imem_gnt = 1'b0;
    branch_target = 32'h0; w_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_gnt_hold();
    test_flush_stall();
    test_reset_mid();
    begin
      bit ok;
      wait_idle(ok);
      total += 2;
      if (!ok) begin bad++; $display("FAIL end_idle got=busy exp=idle"); end
      if (sb.size() != 0) begin bad++; $display("FAIL end_sb_left got=%0d exp=0", sb.size()); end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
